// File: rtl/wide_add_seq_pkg.sv
// Shared definitions for the limb-serial wide adder: limb width and FSM states.
package wide_add_seq_pkg;

  localparam int unsigned LIMB_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/limb_add16.sv
// Combinational 16-bit limb adder with Kogge-Stone carry generation.
module limb_add16
  import wide_add_seq_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              cin,
  output logic [LIMB_W-1:0] sum,
  output logic              cout
);

  localparam int unsigned LEVELS = $clog2(LIMB_W);

  logic [LIMB_W-1:0] p;
  logic [LIMB_W-1:0] g;
  logic [LIMB_W-1:0] gp;

  // cin is folded into bit 0's generate so it reaches every prefix
  always_comb begin
    p  = a ^ b;
    g  = (a & b) | {{(LIMB_W-1){1'b0}}, p[0] & cin};
    gp = p;
    for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
      g  = g | (gp & (g << (1 << lvl)));
      gp = gp & (gp << (1 << lvl));
    end
    sum  = p ^ {g[LIMB_W-2:0], cin};
    cout = g[LIMB_W-1];
  end

endmodule

// File: rtl/wide_add_seq.sv
// Limb-serial W-bit add/subtract: one 16-bit limb per cycle through a single limb adder.
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int unsigned LIMBS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sub,
  input  logic [LIMB_W*LIMBS-1:0] a,
  input  logic [LIMB_W*LIMBS-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LIMB_W*LIMBS-1:0] sum,
  output logic                    carryout,
  output logic                    overflow
);

  localparam int unsigned W  = LIMB_W * LIMBS;
  localparam int unsigned KW = (LIMBS > 1) ? $clog2(LIMBS) : 1;

  state_e            state_q;
  state_e            state_d;
  logic              in_ready_d;
  logic              out_valid_d;
  logic [KW-1:0]     k_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      bx_q;
  logic              carry_q;
  logic              accept;
  logic              last_limb;
  logic [LIMB_W-1:0] a_limb;
  logic [LIMB_W-1:0] b_limb;
  logic [LIMB_W-1:0] limb_sum;
  logic              limb_cout;

  assign accept    = in_valid && in_ready;
  assign last_limb = (k_q == KW'(LIMBS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_limb) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // Pick limb k of the captured operands
  always_comb begin
    a_limb = '0;
    b_limb = '0;
    for (int unsigned i = 0; i < LIMBS; i++) begin
      if (k_q == KW'(i)) begin
        a_limb = a_q[i*LIMB_W +: LIMB_W];
        b_limb = bx_q[i*LIMB_W +: LIMB_W];
      end
    end
  end

  limb_add16 u_limb (
    .a    (a_limb),
    .b    (b_limb),
    .cin  (carry_q),
    .sum  (limb_sum),
    .cout (limb_cout)
  );

  // bx_q holds b already inverted for subtraction; carry_q seeds the +1
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q      <= '0;
      a_q      <= '0;
      bx_q     <= '0;
      carry_q  <= 1'b0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      bx_q    <= sub ? ~b : b;
      carry_q <= sub;
      k_q     <= '0;
    end else if (state_q == RUN) begin
      for (int unsigned i = 0; i < LIMBS; i++) begin
        if (k_q == KW'(i)) sum[i*LIMB_W +: LIMB_W] <= limb_sum;
      end
      carry_q <= limb_cout;
      k_q     <= last_limb ? '0 : k_q + KW'(1);
      if (last_limb) begin
        carryout <= limb_cout;
        overflow <= (a_q[W-1] == bx_q[W-1]) && (limb_sum[LIMB_W-1] != a_q[W-1]);
      end
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Randomised and directed bench for wide_add_seq against a transaction-level reference model.
module tb_wide_add_seq;

  localparam int LIMBS = 4;
  localparam int W     = 16 * LIMBS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carryout;
  logic         overflow;

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  bit           m_busy = 1'b0;
  int           m_age  = 0;
  logic [W-1:0] m_sum  = '0;
  logic         m_c    = 1'b0;
  logic         m_v    = 1'b0;

  wide_add_seq #(.LIMBS(LIMBS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carryout  (carryout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Exact arithmetic: unsigned carry/borrow and signed range check in W+1 bits
  function automatic void ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                 output logic [W-1:0] r, output logic c, output logic v);
    logic [W:0]        full;
    logic signed [W:0] ex;
    if (!s) begin
      full = {1'b0, x} + {1'b0, y};
      r    = full[W-1:0];
      c    = full[W];
      ex   = $signed({x[W-1], x}) + $signed({y[W-1], y});
    end else begin
      r  = x - y;
      c  = (x >= y);
      ex = $signed({x[W-1], x}) - $signed({y[W-1], y});
    end
    v = (ex[W] != ex[W-1]);
  endfunction

  // Transaction timing: busy from accept until the result is taken; valid after LIMBS cycles
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_age  = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_age  = 0;
        ref_op(a, b, sub, m_sum, m_c, m_v);
      end
    end else if (m_age >= LIMBS) begin
      if (out_ready) m_busy = 1'b0;
    end else begin
      m_age++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check1("in_ready", in_ready, !m_busy);
      check1("out_valid", out_valid, m_busy && (m_age >= LIMBS));
      if (m_busy && (m_age >= LIMBS)) begin
        check("model_sum", sum, m_sum);
        check1("model_carryout", carryout, m_c);
        check1("model_overflow", overflow, m_v);
      end
    end
  end

  // Entered and left at a falling edge; returns cycles from accept to first out_valid
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, output int lat);
    a        = x;
    b        = y;
    sub      = s;
    in_valid = 1'b1;
    lat      = 0;
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
    if (!in_ready) begin
      n_checks++;
      n_errs++;
      $display("FAIL accept_timeout: in_ready stayed 0 (t=%0t)", $time);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL valid_timeout: out_valid never rose (t=%0t)", $time);
    end
  endtask

  task automatic finish_xfer(input bit rnd);
    for (int i = 0; i < 200; i++) begin
      if (!out_valid) return;
      out_ready = rnd ? ($urandom_range(7) != 0) : 1'b1;
      @(negedge clk);
    end
    n_checks++;
    n_errs++;
    $display("FAIL xfer_timeout: result never taken (t=%0t)", $time);
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    case ($urandom_range(7))
      0: r = '1;
      1: r = '0;
      2: r = {1'b1, {(W-1){1'b0}}};
      3: r = {1'b0, {(W-1){1'b1}}};
      default: begin
        r = '0;
        for (int i = 0; i < LIMBS; i++) r[i*16 +: 16] = 16'($urandom);
      end
    endcase
    return r;
  endfunction

  initial begin
    int           lat;
    logic [W-1:0] held;
    rst       = 1'b1;
    in_valid  = 1'b0;
    sub       = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_sum", sum, '0);
    check1("rst_carryout", carryout, 1'b0);
    check1("rst_overflow", overflow, 1'b0);
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Carry ripples through every limb
    do_op(64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, lat);
    check_int("ripple_latency", lat, LIMBS + 1);
    check("ripple_sum", sum, 64'h0);
    check1("ripple_carryout", carryout, 1'b1);
    check1("ripple_overflow", overflow, 1'b0);
    finish_xfer(1'b0);

    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat);
    check("ovf_sum", sum, 64'h8000_0000_0000_0000);
    check1("ovf_carryout", carryout, 1'b0);
    check1("ovf_overflow", overflow, 1'b1);
    finish_xfer(1'b0);

    do_op(64'h5, 64'h7, 1'b1, lat);
    check("borrow_sum", sum, 64'hFFFF_FFFF_FFFF_FFFE);
    check1("borrow_carryout", carryout, 1'b0);
    check1("borrow_overflow", overflow, 1'b0);
    finish_xfer(1'b0);

    do_op(64'h7, 64'h5, 1'b1, lat);
    check("noborrow_sum", sum, 64'h2);
    check1("noborrow_carryout", carryout, 1'b1);
    check1("noborrow_overflow", overflow, 1'b0);
    finish_xfer(1'b0);

    // Consumer stalls for 10 cycles
    out_ready = 1'b0;
    do_op(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, lat);
    check("stall_sum", sum, 64'h0000_0001_0000_0000);
    check1("stall_carryout", carryout, 1'b1);
    held = sum;
    for (int i = 0; i < 10; i++) begin
      check("stall_hold_sum", sum, held);
      check1("stall_in_ready", in_ready, 1'b0);
      check1("stall_out_valid", out_valid, 1'b1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check1("release_out_valid", out_valid, 1'b0);
    check1("release_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Reset in the middle of RUN (k=2) aborts the request
    a        = 64'h1111_2222_3333_4444;
    b        = 64'h0101_0101_0101_0101;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_sum", sum, '0);
    check1("abort_carryout", carryout, 1'b0);
    check1("abort_overflow", overflow, 1'b0);
    check1("abort_out_valid", out_valid, 1'b0);
    check1("abort_in_ready", in_ready, 1'b1);
    repeat (8) @(negedge clk);

    do_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, lat);
    check_int("post_abort_latency", lat, LIMBS + 1);
    check("post_abort_sum", sum, 64'h1234_5678_9ABC_DF00);
    check1("post_abort_carryout", carryout, 1'b0);
    check1("post_abort_overflow", overflow, 1'b0);
    finish_xfer(1'b0);

    for (int n = 0; n < 10000; n++) begin
      do_op(rand_w(), rand_w(), 1'(($urandom >> 3) & 1), lat);
      finish_xfer(1'b1);
    end
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    n_errs++;
    $display("FAIL watchdog: simulation time limit reached (t=%0t)", $time);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-002 The block SHALL have the parameter LIMBS, default 4, giving the number of 16-bit limbs; operand width W = 16*LIMBS.
REQ-003 The block SHALL have the following ports, in this order after clk and rst:
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept a request
- sub  input  1  0 = a+b, 1 = a-b
- a  input  W  operand A
- b  input  W  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  W  result
- carryout  output  1  final limb carry; for subtraction, 1 = no borrow
- overflow  output  1  two's-complement signed overflow

Function
REQ-004 A request SHALL be accepted in a cycle where in_valid and in_ready are both 1; a, b and sub are captured on that edge.
REQ-005 The FSM SHALL have three states: IDLE (in_ready=1), RUN (limb index k = 0..LIMBS-1) and DONE (out_valid=1).
REQ-006 FSM transitions SHALL be:
- IDLE->RUN on accept, with k=0
- RUN stays in RUN while k<LIMBS-1, incrementing k
- RUN->DONE after limb LIMBS-1
- DONE->IDLE when out_ready=1
REQ-007 In RUN, one 16-bit limb SHALL be added per cycle, least significant first:
- limb sum = a_k + b'_k + c
- b' = sub ? ~b : b
- c = carry register, loaded with sub at accept and updated with the limb carry each RUN cycle
REQ-008 Each limb result SHALL be written into sum bits [16k+15:16k] on the RUN edge for limb k; higher bits are not disturbed.
REQ-009 Latency SHALL be LIMBS+1 cycles from accept edge to first out_valid=1 cycle (5 cycles at LIMBS=4).
REQ-010 in_ready SHALL be 0 in RUN and DONE; a request presented then is not accepted and is not lost from the requester's view (it must hold in_valid).
REQ-011 sum, carryout and overflow SHALL hold stable while out_valid=1 and out_ready=0.
REQ-012 carryout SHALL equal the carry out of the final limb.
REQ-013 overflow SHALL be (a[W-1]==b'[W-1]) && (sum[W-1]!=a[W-1]).
REQ-014 No new request SHALL be accepted in the DONE->IDLE transfer cycle; the next accept is possible one cycle after the transfer (throughput 1 per LIMBS+2 cycles).
REQ-015 The result SHALL be exact modulo 2^W for all operand values, including an all-ones carry ripple through every limb.

Reset
REQ-016 While rst=1 on a clock edge, the block SHALL enter IDLE with in_ready=1, out_valid=0, sum=0, carryout=0, overflow=0, k=0 and carry register=0.
REQ-017 Reset asserted in RUN or DONE SHALL abort the operation; no out_valid pulse for the aborted request SHALL follow.
REQ-018 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-019 A shared package SHALL hold:
- the limb width constant LIMB_W=16
- the FSM state enumeration (IDLE, RUN, DONE)
REQ-020 One sub-module, limb_add16, SHALL perform the combinational 16-bit limb add:
- inputs a, b, cin; outputs sum, cout
- cin propagated into every sum bit and into cout, using parallel-prefix carry generation
REQ-021 The block SHALL instantiate exactly one limb_add16, with limbs selected by k; no W-bit adder is permitted.

Verification
REQ-022 The bench SHALL cover these directed scenarios (LIMBS=4):
- a=0x0000_0000_0000_0001, b=0xFFFF_FFFF_FFFF_FFFF, sub=0 -> sum=0, carryout=1, overflow=0, out_valid 5 cycles after accept
- a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0x8000_0000_0000_0000, carryout=0, overflow=1
- a=5, b=7, sub=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, carryout=0 (borrow), overflow=0; then a=7, b=5, sub=1 -> sum=2, carryout=1
- out_ready held 0 for 10 cycles -> result stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle
- rst pulsed at RUN k=2 -> all outputs 0 next cycle, no out_valid; a fresh request afterwards completes correctly
- 10,000 random a/b/sub -> sum equal to a±b mod 2^64, flags matching the reference model
